// File: rtl/usb_ctrl_regs_framer_if.sv
// usb_ctrl_regs_framer_if
//   Bundles the frame-request, register-snapshot and byte-stream signals of
//   usb_ctrl_regs_framer.
//   master : frame requester / USB transmitter side (drives tick, reg_*, rdreq)
//   slave  : the framer (drives tx_start, q, last_byte, frame_end, missed)
//
// Byte stream handshake: tx_start acts as "valid" for q/last_byte/frame_end and
// rdreq acts as "ready". A byte is transferred in every cycle where
// tx_start=1 and rdreq=1; the following byte appears on q one cycle later.
// rdreq while tx_start=0 transfers nothing. q, last_byte and frame_end are
// held stable while tx_start=1 and rdreq=0.
interface usb_ctrl_regs_framer_if #(
    parameter int NREGS = 3,
    parameter int MAXB  = 8
);
    logic                      tick;
    logic [NREGS*8-1:0]        reg_addr;
    logic [NREGS*8-1:0]        reg_len;
    logic [NREGS*MAXB*8-1:0]   reg_data;
    logic                      tx_start;
    logic [7:0]                q;
    logic                      rdreq;
    logic                      last_byte;
    logic                      frame_end;
    logic                      missed;

    modport master (
        output tick, reg_addr, reg_len, reg_data, rdreq,
        input  tx_start, q, last_byte, frame_end, missed
    );

    modport slave (
        input  tick, reg_addr, reg_len, reg_data, rdreq,
        output tx_start, q, last_byte, frame_end, missed
    );
endinterface

// File: rtl/usb_ctrl_regs_framer.sv
// usb_ctrl_regs_framer
//   Serialises NREGS control registers into one byte-stream frame per tick.
//   Each record is: addr, 0x00, effective len, then len data bytes (MSB-first).
//   Optional feature macro: CRR_CSUM_EN -- appends one XOR checksum byte
//   covering every preceding frame byte.
// Ports:
//   clk       : clock, rising edge
//   n_rst     : asynchronous active-low reset
//   bus       : usb_ctrl_regs_framer_if.slave (tick, reg_*, tx_start, q,
//               rdreq, last_byte, frame_end, missed)
//   dbg_state : {phase, state} of the FSM for observation
module usb_ctrl_regs_framer #(
    parameter int NREGS = 3,
    parameter int MAXB  = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    usb_ctrl_regs_framer_if.slave       bus,
    output logic [4:0]                  dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;
`ifdef CRR_CSUM_EN
    typedef enum logic [2:0] {PH_ADDR, PH_ZERO, PH_LEN, PH_DATA, PH_CSUM} phase_t;
    localparam bit HAS_CSUM = 1'b1;
`else
    typedef enum logic [2:0] {PH_ADDR, PH_ZERO, PH_LEN, PH_DATA} phase_t;
    localparam bit HAS_CSUM = 1'b0;
`endif

    localparam int             IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IW-1:0]  LAST_REG = IW'(NREGS - 1);
    localparam logic [7:0]     MAXB_B   = 8'(MAXB);

    state_t                    state_q, state_d;
    phase_t                    phase_q, phase_d;
    logic [IW-1:0]             ridx_q, ridx_d;
    logic [7:0]                bidx_q, bidx_d;
    logic [NREGS*8-1:0]        snap_addr_q, snap_addr_d;
    logic [NREGS*8-1:0]        snap_len_q, snap_len_d;
    logic [NREGS*MAXB*8-1:0]   snap_data_q, snap_data_d;
    logic [7:0]                q_q, q_d;
    logic                      last_q, last_d;
    logic                      fend_q, fend_d;
    logic                      missed_q, missed_d;
`ifdef CRR_CSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    logic [7:0]                cur_eff;
    logic                      is_last_reg;
    logic                      rec_end;
    logic                      emit_data;
    logic                      load;

    function automatic logic [7:0] addr_at(input logic [IW-1:0] r);
        return snap_addr_q[32'(r)*8 +: 8];
    endfunction

    function automatic logic [7:0] eff_at(input logic [IW-1:0] r);
        logic [7:0] l;
        l = snap_len_q[32'(r)*8 +: 8];
        return (l > MAXB_B) ? MAXB_B : l;
    endfunction

    function automatic logic [7:0] data_at(input logic [IW-1:0] r, input logic [7:0] j);
        return snap_data_q[(32'(r)*MAXB + MAXB - 1 - 32'(j))*8 +: 8];
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ADDR;
            ridx_q      <= '0;
            bidx_q      <= '0;
            snap_addr_q <= '0;
            snap_len_q  <= '0;
            snap_data_q <= '0;
            q_q         <= '0;
            last_q      <= 1'b0;
            fend_q      <= 1'b0;
            missed_q    <= 1'b0;
`ifdef CRR_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ridx_q      <= ridx_d;
            bidx_q      <= bidx_d;
            snap_addr_q <= snap_addr_d;
            snap_len_q  <= snap_len_d;
            snap_data_q <= snap_data_d;
            q_q         <= q_d;
            last_q      <= last_d;
            fend_q      <= fend_d;
            missed_q    <= missed_d;
`ifdef CRR_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ridx_d      = ridx_q;
        bidx_d      = bidx_q;
        snap_addr_d = snap_addr_q;
        snap_len_d  = snap_len_q;
        snap_data_d = snap_data_q;
        q_d         = q_q;
        last_d      = last_q;
        fend_d      = fend_q;
        missed_d    = 1'b0;
`ifdef CRR_CSUM_EN
        csum_d      = csum_q;
`endif
        cur_eff     = eff_at(ridx_q);
        is_last_reg = (ridx_q == LAST_REG);
        rec_end     = 1'b0;
        emit_data   = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tick) begin
                    // Snapshot comes from the live inputs this cycle, so the
                    // first byte must too (the snapshot flops are not yet loaded).
                    state_d     = ST_SEND;
                    phase_d     = PH_ADDR;
                    ridx_d      = '0;
                    bidx_d      = '0;
                    snap_addr_d = bus.reg_addr;
                    snap_len_d  = bus.reg_len;
                    snap_data_d = bus.reg_data;
                    q_d         = bus.reg_addr[7:0];
                    last_d      = 1'b0;
                    fend_d      = 1'b0;
`ifdef CRR_CSUM_EN
                    csum_d      = bus.reg_addr[7:0];
`endif
                end
            end
            ST_SEND: begin
                missed_d = bus.tick;
                if (bus.rdreq) begin
                    if (fend_q) begin
                        state_d = ST_DONE;
                        q_d     = '0;
                        last_d  = 1'b0;
                        fend_d  = 1'b0;
                    end else begin
                        load = 1'b1;
                        case (phase_q)
                            PH_ADDR: begin
                                phase_d = PH_ZERO;
                                q_d     = 8'h00;
                            end
                            PH_ZERO: begin
                                phase_d = PH_LEN;
                                q_d     = cur_eff;
                                last_d  = (cur_eff == 8'd0);
                                fend_d  = (cur_eff == 8'd0) && is_last_reg && !HAS_CSUM;
                            end
                            PH_LEN: begin
                                if (cur_eff == 8'd0) begin
                                    rec_end = 1'b1;
                                end else begin
                                    phase_d   = PH_DATA;
                                    bidx_d    = '0;
                                    emit_data = 1'b1;
                                end
                            end
                            PH_DATA: begin
                                if (({1'b0, bidx_q} + 9'd1) == {1'b0, cur_eff}) begin
                                    rec_end = 1'b1;
                                end else begin
                                    bidx_d    = bidx_q + 8'd1;
                                    emit_data = 1'b1;
                                end
                            end
                            default: ;
                        endcase

                        if (emit_data) begin
                            q_d    = data_at(ridx_q, bidx_d);
                            last_d = ({1'b0, bidx_d} + 9'd1) == {1'b0, cur_eff};
                            fend_d = last_d && is_last_reg && !HAS_CSUM;
                        end

                        // Without a checksum the final record end always carries
                        // frame_end, so only the CRR_CSUM_EN build reaches the
                        // is_last_reg branch here.
                        if (rec_end) begin
                            if (is_last_reg) begin
`ifdef CRR_CSUM_EN
                                phase_d = PH_CSUM;
                                q_d     = csum_q;
                                last_d  = 1'b0;
                                fend_d  = 1'b1;
`endif
                            end else begin
                                ridx_d  = ridx_q + 1'b1;
                                phase_d = PH_ADDR;
                                q_d     = addr_at(ridx_d);
                                last_d  = 1'b0;
                                fend_d  = 1'b0;
                            end
                        end
                    end
                end
`ifdef CRR_CSUM_EN
                if (load && (phase_d != PH_CSUM)) begin
                    csum_d = csum_q ^ q_d;
                end
`endif
            end
            ST_DONE: begin
                missed_d = bus.tick;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.tx_start  = (state_q == ST_SEND);
    assign bus.q         = q_q;
    assign bus.last_byte = last_q;
    assign bus.frame_end = fend_q;
    assign bus.missed    = missed_q;
    assign dbg_state     = {phase_q, state_q};

endmodule

// File: tb/tb_usb_ctrl_regs_framer.sv
// tb_usb_ctrl_regs_framer
//   Bench for usb_ctrl_regs_framer. Expected frame bytes {last, end, q} are
//   built from the register values present when tick is driven, queued, and
//   popped as the bench consumes bytes with rdreq.
module tb_usb_ctrl_regs_framer;
    localparam int NREGS = 3;
    localparam int MAXB  = 8;
`ifdef CRR_CSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic [4:0] dbg_state;

    usb_ctrl_regs_framer_if #(.NREGS(NREGS), .MAXB(MAXB)) bus ();

    usb_ctrl_regs_framer #(.NREGS(NREGS), .MAXB(MAXB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         bad;
    int         missed_cnt;
    logic [9:0] exp_q[$];
    logic [7:0] model_cs;

    always @(negedge clk) begin
        if (bus.missed === 1'b1) missed_cnt++;
    end

    // ---------------- model / driver tasks ----------------
    task automatic push_byte(input logic [7:0] b, input bit l, input bit f);
        exp_q.push_back({l, f, b});
        model_cs ^= b;
    endtask

    task automatic push_expected();
        logic [7:0] eff;
        logic [7:0] ln;
        bit         lastreg;
        model_cs = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            ln      = bus.reg_len[i*8 +: 8];
            eff     = (ln > 8'(MAXB)) ? 8'(MAXB) : ln;
            lastreg = (i == NREGS - 1);
            push_byte(bus.reg_addr[i*8 +: 8], 1'b0, 1'b0);
            push_byte(8'h00, 1'b0, 1'b0);
            push_byte(eff, eff == 0, (eff == 0) && lastreg && !HAS_CSUM);
            for (int j = 0; j < int'(eff); j++) begin
                push_byte(bus.reg_data[(i*MAXB + MAXB - 1 - j)*8 +: 8],
                          j == int'(eff) - 1,
                          (j == int'(eff) - 1) && lastreg && !HAS_CSUM);
            end
        end
        if (HAS_CSUM) exp_q.push_back({1'b0, 1'b1, model_cs});
    endtask

    task automatic load_regs(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                             input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                             input logic [7:0] seed);
        bus.reg_addr = {a2, a1, a0};
        bus.reg_len  = {l2, l1, l0};
        for (int i = 0; i < NREGS; i++)
            for (int j = 0; j < MAXB; j++)
                bus.reg_data[(i*MAXB + MAXB - 1 - j)*8 +: 8] = seed + 8'(i*MAXB + j);
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < NREGS*MAXB; k++) bus.reg_data[k*8 +: 8] = 8'($urandom);
        for (int k = 0; k < NREGS; k++) begin
            bus.reg_addr[k*8 +: 8] = 8'($urandom);
            bus.reg_len[k*8 +: 8]  = 8'($urandom);
        end
    endtask

    task automatic send_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        push_expected();
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    // Consumes queued bytes with random rdreq gaps. tick_at >= 0 raises tick in
    // the cycle that consumes byte tick_at; tick_on_last raises tick together
    // with the final rdreq; stop_after >= 0 stops once that many bytes are taken.
    task automatic drain_frame(input bit scramble, input int tick_at, input bit tick_on_last,
                               input int stop_after, output int popped);
        int         guard;
        logic [9:0] exp;
        bit         stopped;
        guard   = 0;
        popped  = 0;
        stopped = 1'b0;
        while (exp_q.size() != 0) begin
            bus.tick = 1'b0;
            total++;
            if (bus.tx_start !== 1'b1) begin
                bad++;
                $display("FAIL tx_start_valid: got %b want 1 at byte %0d", bus.tx_start, popped);
                exp_q.delete();
                break;
            end
            if (stop_after >= 0 && popped == stop_after) begin
                stopped = 1'b1;
                break;
            end
            if ($urandom_range(0, 3) != 0) begin
                exp = exp_q.pop_front();
                total++;
                if ({bus.last_byte, bus.frame_end, bus.q} !== exp) begin
                    bad++;
                    $display("FAIL frame_byte[%0d]: got last=%b end=%b q=%02h want last=%b end=%b q=%02h",
                             popped, bus.last_byte, bus.frame_end, bus.q, exp[9], exp[8], exp[7:0]);
                end
                bus.rdreq = 1'b1;
                if (popped == tick_at) bus.tick = 1'b1;
                if (tick_on_last && exp_q.size() == 0) bus.tick = 1'b1;
                popped++;
            end else begin
                bus.rdreq = 1'b0;
            end
            if (scramble) scramble_inputs();
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                bad++;
                $display("FAIL drain_timeout: got %0d bytes left want 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        bus.rdreq = 1'b0;
        bus.tick  = 1'b0;
        if (!stopped) begin
            total++;
            if (bus.tx_start !== 1'b0) begin
                bad++;
                $display("FAIL tx_start_after_frame: got %b want 0", bus.tx_start);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string name);
        total++;
        if ({bus.tx_start, bus.q, bus.last_byte, bus.frame_end, bus.missed} !== 12'h000) begin
            bad++;
            $display("FAIL %s: got tx=%b q=%02h last=%b end=%b missed=%b want all 0",
                     name, bus.tx_start, bus.q, bus.last_byte, bus.frame_end, bus.missed);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_rst     = 1'b0;
        bus.tick  = 1'b0;
        bus.rdreq = 1'b0;
        load_regs(8'h01, 8'h02, 8'h03, 8'd8, 8'd2, 8'd3, 8'h11);
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        n_rst = 1'b1;
        bus.rdreq = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("rdreq_in_idle");
        bus.rdreq = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        load_regs(8'h01, 8'h02, 8'h03, 8'd8, 8'd2, 8'd3, 8'h11);
        send_tick();
        drain_frame(1'b0, -1, 1'b0, -1, n);
        total++;
        if (n !== 22 + int'(HAS_CSUM)) begin
            bad++;
            $display("FAIL basic_len: got %0d want %0d", n, 22 + int'(HAS_CSUM));
        end
    endtask

    task automatic test_len_edges();
        int n;
        load_regs(8'h01, 8'h02, 8'h03, 8'd4, 8'd0, 8'd20, 8'h40);
        send_tick();
        drain_frame(1'b0, -1, 1'b0, -1, n);
        total++;
        if (n !== 7 + 3 + 11 + int'(HAS_CSUM)) begin
            bad++;
            $display("FAIL len_edges_len: got %0d want %0d", n, 21 + int'(HAS_CSUM));
        end
    endtask

    task automatic test_snapshot();
        int n;
        load_regs(8'hA1, 8'hB2, 8'hC3, 8'd5, 8'd7, 8'd1, 8'h80);
        send_tick();
        drain_frame(1'b1, -1, 1'b0, -1, n);
    endtask

    task automatic test_missed();
        int n;
        int m0;
        m0 = missed_cnt;
        load_regs(8'h11, 8'h22, 8'h33, 8'd3, 8'd2, 8'd1, 8'h05);
        send_tick();
        drain_frame(1'b0, 4, 1'b1, -1, n);
        repeat (5) begin
            total++;
            if (bus.tx_start !== 1'b0) begin
                bad++;
                $display("FAIL no_second_frame: got tx_start=%b want 0", bus.tx_start);
            end
            @(negedge clk);
        end
        total++;
        if (missed_cnt - m0 !== 2) begin
            bad++;
            $display("FAIL missed_count: got %0d want 2", missed_cnt - m0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        load_regs(8'h01, 8'h02, 8'h03, 8'd8, 8'd2, 8'd3, 8'h11);
        send_tick();
        drain_frame(1'b0, -1, 1'b0, 5, n);
        n_rst = 1'b0;
        #1;
        check_quiet("reset_mid_outputs");
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        bus.rdreq = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("rdreq_after_reset");
        bus.rdreq = 1'b0;
        load_regs(8'h09, 8'h08, 8'h07, 8'd2, 8'd3, 8'd4, 8'h60);
        send_tick();
        drain_frame(1'b0, -1, 1'b0, -1, n);
        total++;
        if (n !== 18 + int'(HAS_CSUM)) begin
            bad++;
            $display("FAIL post_reset_len: got %0d want %0d", n, 18 + int'(HAS_CSUM));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int r = 0; r < 4; r++) begin
            load_regs(8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                      8'($urandom_range(0, 12)), 8'($urandom));
            send_tick();
            drain_frame(1'b0, -1, 1'b0, -1, n);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        missed_cnt = 0;
        model_cs   = 8'h00;
        n_rst      = 1'b0;
        bus.tick   = 1'b0;
        bus.rdreq  = 1'b0;
        bus.reg_addr = '0;
        bus.reg_len  = '0;
        bus.reg_data = '0;
        test_reset();
        test_basic();
        test_len_edges();
        test_snapshot();
        test_missed();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_ctrl_regs_framer.md
USB_CTRL_REGS_FRAMER -- requirements
Module: usb_ctrl_regs_framer

Interface
REQ-001 Parameter NREGS, 3, number of control registers serialised per frame (1..16).
REQ-002 Parameter MAXB, 8, maximum data bytes per register (1..255).
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle frame request (100 ms timebase).
REQ-006 reg_addr  input  NREGS*8  register i address byte at [8i+7:8i].
REQ-007 reg_len  input  NREGS*8  register i data byte count at [8i+7:8i].
REQ-008 reg_data  input  NREGS*MAXB*8  register i, MSB-first; byte j of register i at [(i*MAXB+MAXB-1-j)*8 +: 8].
REQ-009 tx_start  output  1  frame available to the USB transmitter.
REQ-010 q  output  8  current frame byte.
REQ-011 rdreq  input  1  consumes the current byte.
REQ-012 last_byte  output  1  q is the final byte of a register record.
REQ-013 frame_end  output  1  q is the final byte of the frame.
REQ-014 missed  output  1  one-cycle pulse when tick is dropped.

Function
REQ-015 Frame: for i = 0..NREGS-1, the record is addr, 0x00, len, then len data bytes; with CRR_CSUM_EN defined, one checksum byte is appended after the last record.
REQ-016 Effective len is min(reg_len, MAXB); the length byte sent is the effective len.
REQ-017 On tick in IDLE: reg_addr, reg_len and reg_data are snapshotted into internal registers the same cycle; the FSM enters SEND; tx_start is 1 from the next cycle.
REQ-018 The frame is built only from the snapshot; input changes during SEND do not affect the frame.
REQ-019 FSM states: IDLE, SEND (sub-phase ADDR, ZERO, LEN, DATA, CSUM), DONE.
REQ-020 In SEND, q, last_byte and frame_end are registered and valid while tx_start=1; rdreq in cycle n advances the pointer; the next byte is on q in cycle n+1.
REQ-021 rdreq in IDLE or DONE is ignored; no underflow and no pointer change.
REQ-022 A record with effective len 0 is ADDR, ZERO, LEN only; last_byte is asserted on its LEN byte.
REQ-023 last_byte is asserted on the last data byte of each record (or LEN if len=0); it is not asserted on the checksum byte.
REQ-024 frame_end is asserted on the last byte of the frame (the checksum byte, or the final record's last byte).
REQ-025 rdreq while frame_end=1 moves the FSM to DONE; tx_start is 0 from the next cycle; DONE returns to IDLE after one cycle.
REQ-026 tick in SEND or DONE is not queued; missed pulses 1 the following cycle.
REQ-027 tick and the final rdreq in the same cycle: the tick is dropped and missed pulses.
REQ-028 No tx_start deassertion occurs mid-frame other than by reset.

Reset
REQ-029 n_rst low gives FSM IDLE, pointers 0, snapshot 0, tx_start 0, q 0x00, last_byte 0, frame_end 0, missed 0.
REQ-030 Reset mid-frame abandons the frame; after release, the block waits for a new tick.

Configuration
REQ-031 Macro CRR_CSUM_EN defined appends a checksum byte (XOR of every preceding frame byte, including addr, 0x00 and len bytes) as the final frame byte.
REQ-032 Macro CRR_CSUM_EN undefined leaves no checksum logic and no CSUM phase; the frame ends on the last record's last byte.

Verification
REQ-033 Defaults, no macro; addrs 0x01/0x02/0x03, lens 8/2/3, data 0x11.. -> 22 bytes: 01 00 08 d0..d7 02 00 02 .. 03 00 03 ..; last_byte at byte indices 10, 15 and 21; frame_end at 21.
REQ-034 Ignoring CRR_CSUM_EN, reg_len[1]=0 -> record 1 is 02 00 00 with last_byte on its 00 LEN byte; reg_len[2]=20 with MAXB=8 -> length byte 0x08 and 8 data bytes.
REQ-035 Ignoring CRR_CSUM_EN, change reg_data on every cycle during SEND -> q stream matches the tick-cycle snapshot.
REQ-036 Ignoring CRR_CSUM_EN, tick during SEND and tick together with the final rdreq -> missed pulses once each; no second frame; tx_start is 0 after DONE.
REQ-037 With CRR_CSUM_EN, REQ-033 data -> 23 bytes; byte 22 is the XOR of bytes 0..21; frame_end is on byte 22 only.
REQ-038 Ignoring CRR_CSUM_EN, n_rst pulsed at byte 5 -> all outputs 0; after release, rdreq is ignored and the next tick yields a complete frame from byte 0.
